// File: rtl/interrupt_controller.sv
// Single-level interrupt responder: accepts a software or hardware request,
// drains the front end, vectors fetch to the handler and returns to the saved PC.
module interrupt_controller #(
    parameter logic [15:0] HANDLER_ADDR = 16'h0008,
    parameter logic [3:0]  HW_CAUSE     = 4'hF,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interruptSignal,
    input  logic [3:0]  interruptIndex,
    input  logic        eret,
    input  logic        hwIrq,
    input  logic [15:0] pcNext,
    output logic        stall,
    output logic        pcLoad,
    output logic [15:0] pcTarget,
    output logic [15:0] epc,
    output logic [3:0]  cause,
    output logic        inHandler,
    output logic [15:0] intCount
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FLUSH   = 3'd1;
    localparam logic [2:0] VECTOR  = 3'd2;
    localparam logic [2:0] HANDLER = 3'd3;
    localparam logic [2:0] RETURN  = 3'd4;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] nextState;
    logic [3:0] flushCount;
    logic       swReq;
    logic       accept;

    // Strobes from the decoder are active-low; software wins over hardware.
    assign swReq  = ~interruptSignal;
    assign accept = (state == IDLE) && (swReq || hwIrq);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = FLUSH;
            FLUSH:   if (flushCount == 4'd0) nextState = VECTOR;
            VECTOR:  nextState = HANDLER;
            HANDLER: if (!eret) nextState = RETURN;
            RETURN:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The drain counter is loaded on the accept edge so FLUSH lasts exactly FLUSH_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flushCount <= 4'd0;
        end else if (accept) begin
            flushCount <= FLUSH_LOAD;
        end else if (state == FLUSH && flushCount != 4'd0) begin
            flushCount <= flushCount - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc      <= 16'h0000;
            cause    <= 4'h0;
            intCount <= 16'h0000;
        end else if (accept) begin
            epc      <= pcNext;
            cause    <= swReq ? interruptIndex : HW_CAUSE;
            intCount <= intCount + 16'd1;
        end
    end

    always_comb begin
        stall     = 1'b0;
        pcLoad    = 1'b0;
        pcTarget  = 16'h0000;
        inHandler = 1'b0;
        case (state)
            FLUSH: begin
                stall = 1'b1;
            end
            VECTOR: begin
                stall     = 1'b1;
                pcLoad    = 1'b1;
                pcTarget  = HANDLER_ADDR;
                inHandler = 1'b1;
            end
            HANDLER: begin
                inHandler = 1'b1;
            end
            RETURN: begin
                stall    = 1'b1;
                pcLoad   = 1'b1;
                pcTarget = epc;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: a cycle-count model of the interrupt service
// sequence checked every cycle, plus directed literal expectations.
module tb_interrupt_controller;

    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        interruptSignal = 1'b1;
    logic [3:0]  interruptIndex = 4'h0;
    logic        eret = 1'b1;
    logic        hwIrq = 1'b0;
    logic [15:0] pcNext = 16'h0000;
    logic        stall;
    logic        pcLoad;
    logic [15:0] pcTarget;
    logic [15:0] epc;
    logic [3:0]  cause;
    logic        inHandler;
    logic [15:0] intCount;

    int checks = 0;
    int fails = 0;

    bit          compareOn = 1'b0;
    bit          litValid = 1'b0;
    string       litName = "";
    logic [54:0] litExpect = '0;
    logic [15:0] countOffset = 16'h0000;

    // Model: mEntry counts cycles since accept (1..FLUSH_CYCLES drain, then vector).
    int          mEntry = 0;
    bit          mHandling = 1'b0;
    bit          mReturning = 1'b0;
    logic [15:0] mEpc = 16'h0000;
    logic [3:0]  mCause = 4'h0;
    logic [15:0] mCount = 16'h0000;

    logic [54:0] dutVec;

    interrupt_controller #(
        .HANDLER_ADDR(16'h0008),
        .HW_CAUSE(4'hF),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .interruptSignal(interruptSignal),
        .interruptIndex(interruptIndex),
        .eret(eret),
        .hwIrq(hwIrq),
        .pcNext(pcNext),
        .stall(stall),
        .pcLoad(pcLoad),
        .pcTarget(pcTarget),
        .epc(epc),
        .cause(cause),
        .inHandler(inHandler),
        .intCount(intCount)
    );

    always #5 clk = ~clk;

    assign dutVec = {stall, pcLoad, pcTarget, epc, cause, inHandler, intCount};

    function automatic logic [54:0] pack(input logic s, input logic l, input logic [15:0] t,
                                         input logic [15:0] e, input logic [3:0] c,
                                         input logic h, input logic [15:0] n);
        return {s, l, t, e, c, h, n};
    endfunction

    function automatic logic [54:0] modelOut();
        logic vectoring;
        logic [15:0] target;
        vectoring = (mEntry == FLUSH_CYCLES + 1);
        target = vectoring ? 16'h0008 : (mReturning ? mEpc : 16'h0000);
        return pack((mEntry != 0) || mReturning, vectoring || mReturning, target,
                    mEpc, mCause, vectoring || mHandling, mCount + countOffset);
    endfunction

    // Behavioural model of the service sequence, advanced once per rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mEntry = 0;
            mHandling = 1'b0;
            mReturning = 1'b0;
            mEpc = 16'h0000;
            mCause = 4'h0;
            mCount = 16'h0000;
        end else if (mReturning) begin
            mReturning = 1'b0;
        end else if (mEntry != 0) begin
            if (mEntry == FLUSH_CYCLES + 1) begin
                mEntry = 0;
                mHandling = 1'b1;
            end else begin
                mEntry = mEntry + 1;
            end
        end else if (mHandling) begin
            if (!eret) begin
                mHandling = 1'b0;
                mReturning = 1'b1;
            end
        end else if (!interruptSignal || hwIrq) begin
            mEpc = pcNext;
            mCause = !interruptSignal ? interruptIndex : 4'hF;
            mCount = mCount + 16'd1;
            mEntry = 1;
        end
    end

    // Single compare point, mid-cycle, against the model and any pinned literal.
    always @(negedge clk) begin
        if (compareOn) begin
            checks++;
            if (dutVec !== modelOut()) begin
                fails++;
                $display("[TB] FAIL model t=%0t actual=%h required=%h", $time, dutVec, modelOut());
            end
            if (litValid) begin
                checks++;
                if (dutVec !== litExpect) begin
                    fails++;
                    $display("[TB] FAIL %s t=%0t actual=%h required=%h", litName, $time, dutVec, litExpect);
                end
            end
        end
    end

    task automatic applyStimulus(input logic sig, input logic [3:0] idx, input logic er,
                                 input logic hw, input logic [15:0] pc);
        @(posedge clk);
        #2;
        interruptSignal = sig;
        interruptIndex = idx;
        eret = er;
        hwIrq = hw;
        pcNext = pc;
        litValid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [54:0] required);
        litName = name;
        litExpect = required;
        litValid = 1'b1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        interruptSignal = 1'b1;
        eret = 1'b1;
        hwIrq = 1'b0;
        countOffset = 16'h0000;
        compareOn = 1'b1;
        checkOutput("resetState", '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        litValid = 1'b0;
    endtask

    initial begin
        $display("[TB] start");

        // Software interrupt entry and return
        doReset();
        applyStimulus(1'b0, 4'h3, 1'b1, 1'b0, 16'h0123);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0124);
        checkOutput("swFlush1", pack(1, 0, 16'h0000, 16'h0123, 4'h3, 0, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0124);
        checkOutput("swFlush2", pack(1, 0, 16'h0000, 16'h0123, 4'h3, 0, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0124);
        checkOutput("swVector", pack(1, 1, 16'h0008, 16'h0123, 4'h3, 1, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0008);
        checkOutput("swHandler", pack(0, 0, 16'h0000, 16'h0123, 4'h3, 1, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0009);
        checkOutput("eretHandler", pack(0, 0, 16'h0000, 16'h0123, 4'h3, 1, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h000A);
        checkOutput("returnCycle", pack(1, 1, 16'h0123, 16'h0123, 4'h3, 0, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0123);
        checkOutput("afterReturn", pack(0, 0, 16'h0000, 16'h0123, 4'h3, 0, 16'd1));

        // Priority, hardware re-entry, no nesting
        doReset();
        applyStimulus(1'b0, 4'h5, 1'b1, 1'b1, 16'h0200);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 16'h0200);
        checkOutput("prioFlush1", pack(1, 0, 16'h0000, 16'h0200, 4'h5, 0, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 16'h0200);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 16'h0200);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 16'h0200);
        checkOutput("prioHandler", pack(0, 0, 16'h0000, 16'h0200, 4'h5, 1, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 16'h0200);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 16'h0200);
        checkOutput("prioReturn", pack(1, 1, 16'h0200, 16'h0200, 4'h5, 0, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 16'h0200);
        checkOutput("idleHwHeld", pack(0, 0, 16'h0000, 16'h0200, 4'h5, 0, 16'd1));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0200);
        checkOutput("hwReentry", pack(1, 0, 16'h0000, 16'h0200, 4'hF, 0, 16'd2));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0200);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0200);
        checkOutput("hwVector", pack(1, 1, 16'h0008, 16'h0200, 4'hF, 1, 16'd2));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'h7, 1'b1, 1'b1, 16'hBEEF);
            checkOutput("noNesting", pack(0, 0, 16'h0000, 16'h0200, 4'hF, 1, 16'd2));
        end
        applyStimulus(1'b0, 4'h9, 1'b0, 1'b0, 16'hBEEF);
        checkOutput("noNesting", pack(0, 0, 16'h0000, 16'h0200, 4'hF, 1, 16'd2));
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0300);
        checkOutput("eretWins", pack(1, 1, 16'h0200, 16'h0200, 4'hF, 0, 16'd2));
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0300);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0300);
        checkOutput("eretInIdle", pack(0, 0, 16'h0000, 16'h0200, 4'hF, 0, 16'd2));

        // Count wrap, then abort from FLUSH
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0300);
        force dut.intCount = 16'hFFFF;
        countOffset = 16'hFFFF - mCount;
        #1;
        release dut.intCount;
        applyStimulus(1'b0, 4'h1, 1'b1, 1'b0, 16'h0300);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0301);
        checkOutput("countWrap", pack(1, 0, 16'h0000, 16'h0300, 4'h1, 0, 16'd0));
        doReset();
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 16'h0301);
        checkOutput("afterAbort", '0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0,
                              $urandom_range(0, 2) == 0, 16'($urandom));
            end
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
